// File: rtl/selectio_bitslip_align_if.sv
// Bus between the bitslip alignment controller and its neighbours: the
// deserialized word stream in, and bitslip/lock status plus aligned data out.
interface selectio_bitslip_align_if #(
  parameter int DW      = 4,
  parameter int SP_Mult = 4
);
  logic                    i_start;
  logic [DW*SP_Mult-1:0]   i_pardata;
  logic [DW-1:0]           o_bitslip;
  logic [DW-1:0]           o_lane_locked;
  logic [DW-1:0]           o_lane_fail;
  logic                    o_all_locked;
  logic [DW*SP_Mult-1:0]   o_pardata;
  logic                    o_pardata_vld;

  // The side that feeds words in and consumes the aligned stream.
  modport master (
    output i_start, i_pardata,
    input  o_bitslip, o_lane_locked, o_lane_fail, o_all_locked, o_pardata, o_pardata_vld
  );

  // The alignment controller itself.
  modport slave (
    input  i_start, i_pardata,
    output o_bitslip, o_lane_locked, o_lane_fail, o_all_locked, o_pardata, o_pardata_vld
  );
endinterface

// File: rtl/selectio_bitslip_align.sv
// Word-alignment controller for the ISERDES output. Each lane independently
// pulses its bitslip until its lane word equals the training pattern for a run
// of consecutive words, then holds lock. Aligned data is forwarded with a valid
// flag once every lane is locked.
module selectio_bitslip_align #(
  parameter int                 DW         = 4,
  parameter int                 SP_Mult    = 4,
  parameter logic [SP_Mult-1:0] TRAIN_PAT  = 4'b0011,
  parameter int                 SETTLE_CYC = 4,
  parameter int                 MATCH_CNT  = 8,
  parameter int                 MAX_SLIP   = 7
) (
  input  logic                     i_fclk,
  input  logic                     i_rst_n,
  selectio_bitslip_align_if.slave  bus
);

  localparam int SLIP_W = (MAX_SLIP < 1) ? 1 : $clog2(MAX_SLIP + 1);

  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0]        MATCH_LAST  = 8'(MATCH_CNT - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(MAX_SLIP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } lane_state_t;

  logic [DW-1:0]         bitslip_vec;
  logic [DW-1:0]         locked_vec;
  logic [DW-1:0]         fail_vec;
  logic [DW*SP_Mult-1:0] pardata_q;
  logic                  pardata_vld_q;

  for (genvar lane = 0; lane < DW; lane++) begin : g_lane
    logic [SP_Mult-1:0] lane_word;
    lane_state_t        state;
    logic [3:0]         settle_cnt;
    logic [7:0]         match_cnt;
    logic [SLIP_W-1:0]  slip_cnt;
    logic               bitslip_q;
    logic               locked_q;
    logic               fail_q;

    // Gather this lane's samples out of the interleaved parallel word.
    always_comb begin
      lane_word = '0;
      for (int k = 0; k < SP_Mult; k++) begin
        lane_word[k] = bus.i_pardata[DW*k + lane];
      end
    end

    // Per-lane training FSM; a start pulse restarts the search from any state.
    always_ff @(posedge i_fclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state      <= ST_IDLE;
        settle_cnt <= '0;
        match_cnt  <= '0;
        slip_cnt   <= '0;
        bitslip_q  <= 1'b0;
        locked_q   <= 1'b0;
        fail_q     <= 1'b0;
      end else if (bus.i_start) begin
        state      <= ST_WAIT;
        settle_cnt <= '0;
        match_cnt  <= '0;
        slip_cnt   <= '0;
        bitslip_q  <= 1'b0;
        locked_q   <= 1'b0;
        fail_q     <= 1'b0;
      end else begin
        bitslip_q <= 1'b0;
        case (state)
          ST_IDLE: begin
          end
          ST_WAIT: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          ST_CHECK: begin
            if (lane_word == TRAIN_PAT) begin
              match_cnt <= match_cnt + 8'd1;
              if (match_cnt == MATCH_LAST) begin
                state    <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              if (slip_cnt == SLIP_LAST) begin
                state  <= ST_FAIL;
                fail_q <= 1'b1;
              end else begin
                state     <= ST_SLIP;
                bitslip_q <= 1'b1;
              end
            end
          end
          ST_SLIP: begin
            slip_cnt   <= slip_cnt + 1'b1;
            settle_cnt <= '0;
            state      <= ST_WAIT;
          end
          ST_LOCKED, ST_FAIL: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign bitslip_vec[lane] = bitslip_q;
    assign locked_vec[lane]  = locked_q;
    assign fail_vec[lane]    = fail_q;
  end

  // Forward the raw word one cycle late, flagged valid once all lanes locked.
  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pardata_q     <= '0;
      pardata_vld_q <= 1'b0;
    end else begin
      pardata_q     <= bus.i_pardata;
      pardata_vld_q <= &locked_vec;
    end
  end

  assign bus.o_bitslip     = bitslip_vec;
  assign bus.o_lane_locked = locked_vec;
  assign bus.o_lane_fail   = fail_vec;
  assign bus.o_all_locked  = &locked_vec;
  assign bus.o_pardata     = pardata_q;
  assign bus.o_pardata_vld = pardata_vld_q;

endmodule

// File: tb/tb_selectio_bitslip_align.sv
// Bench for the bitslip alignment controller: a loopback model rotates each
// lane word on every bitslip pulse, scenarios come from a table, and a few
// hand-written sequences cover reset mid-slip and restart after lock.
module tb_selectio_bitslip_align;
  localparam int DW       = 4;
  localparam int SP_MULT  = 4;
  localparam int W        = DW * SP_MULT;
  localparam int RUN_CYC  = 60;
  localparam int SLIP_GAP = 6;

  typedef struct packed {
    logic [3:0][3:0] base;
    logic            loopback;
    logic [7:0]      glitch_cyc;
    logic [3:0]      glitch_mask;
    logic [3:0][3:0] exp_slips;
    logic [3:0]      exp_locked;
    logic [3:0]      exp_fail;
    logic [7:0]      exp_lock_cyc;
  } scen_t;

  logic i_fclk;
  logic i_rst_n;

  selectio_bitslip_align_if #(.DW(DW), .SP_Mult(SP_MULT)) bus ();

  selectio_bitslip_align #(
    .DW(DW), .SP_Mult(SP_MULT), .TRAIN_PAT(4'b0011),
    .SETTLE_CYC(4), .MATCH_CNT(8), .MAX_SLIP(7)
  ) dut (
    .i_fclk (i_fclk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  logic [3:0]   base [4];
  int           rot [4];
  int           pulses [4];
  int           last_pulse [4];
  bit           loopback;
  bit           rand_mode;
  int           glitch_cyc;
  logic [3:0]   glitch_mask;
  int           cyc;
  logic [W-1:0] drv;
  logic [W-1:0] prev_drv;
  int           exp_lock_cyc;
  bit           exp_all_prev;
  int           first_lock;
  int           gap_err;
  int           errors;
  int           checks;
  scen_t        scen [6];

  // Free-running parallel clock.
  initial begin
    i_fclk = 1'b0;
    forever #5 i_fclk = ~i_fclk;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] rotl1(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic scen_t mk(input logic [15:0] bases, input logic lb, input int gc,
                               input logic [3:0] gm, input logic [15:0] slips,
                               input logic [3:0] lk, input logic [3:0] fl, input int lc);
    scen_t s;
    s.base         = bases;
    s.loopback     = lb;
    s.glitch_cyc   = 8'(gc);
    s.glitch_mask  = gm;
    s.exp_slips    = slips;
    s.exp_locked   = lk;
    s.exp_fail     = fl;
    s.exp_lock_cyc = 8'(lc);
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Loopback model: each lane word is its base pattern rotated once per slip.
  task automatic driveData();
    logic [3:0]   w;
    logic [W-1:0] p;
    p = '0;
    if (rand_mode) begin
      p = W'($urandom);
    end else begin
      for (int lane = 0; lane < DW; lane++) begin
        w = base[lane];
        if (loopback) begin
          for (int r = 0; r < rot[lane] % 4; r++) w = rotl1(w);
        end
        if (glitch_mask[lane] && cyc == glitch_cyc) w = 4'b0000;
        for (int k = 0; k < SP_MULT; k++) p[DW*k + lane] = w[k];
      end
    end
    bus.i_pardata = p;
    drv = p;
  endtask

  task automatic stepCycle();
    bit exp_all;
    prev_drv = drv;
    @(posedge i_fclk);
    cyc++;
    @(negedge i_fclk);
    bus.i_start = 1'b0;
    exp_all = (exp_lock_cyc != 0) && (cyc >= exp_lock_cyc);
    checkOutput("all_locked", 32'(bus.o_all_locked), 32'(exp_all));
    checkOutput("pardata_vld", 32'(bus.o_pardata_vld), 32'(exp_all_prev));
    checkOutput("pardata", 32'(bus.o_pardata), 32'(prev_drv));
    exp_all_prev = exp_all;
    for (int lane = 0; lane < DW; lane++) begin
      if (bus.o_bitslip[lane]) begin
        if (pulses[lane] > 0 && cyc - last_pulse[lane] < SLIP_GAP) gap_err++;
        pulses[lane]++;
        last_pulse[lane] = cyc;
        rot[lane]++;
      end
    end
    if (bus.o_all_locked && first_lock == 0) first_lock = cyc;
    driveData();
  endtask

  // Called on a falling edge; the start pulse is seen on the next rising edge.
  task automatic startTraining();
    for (int lane = 0; lane < DW; lane++) begin
      rot[lane]        = 0;
      pulses[lane]     = 0;
      last_pulse[lane] = 0;
    end
    cyc        = 0;
    first_lock = 0;
    gap_err    = 0;
    driveData();
    bus.i_start = 1'b1;
  endtask

  task automatic applyStimulus(input scen_t s, input int idx);
    for (int lane = 0; lane < DW; lane++) base[lane] = s.base[lane];
    loopback     = s.loopback;
    glitch_cyc   = int'(s.glitch_cyc);
    glitch_mask  = s.glitch_mask;
    rand_mode    = 1'b0;
    exp_lock_cyc = int'(s.exp_lock_cyc);
    startTraining();
    repeat (RUN_CYC) stepCycle();
    for (int lane = 0; lane < DW; lane++) begin
      checkOutput($sformatf("s%0d slips lane%0d", idx, lane), 32'(pulses[lane]),
                  32'(s.exp_slips[lane]));
    end
    checkOutput($sformatf("s%0d lane_locked", idx), 32'(bus.o_lane_locked), 32'(s.exp_locked));
    checkOutput($sformatf("s%0d lane_fail", idx), 32'(bus.o_lane_fail), 32'(s.exp_fail));
    checkOutput($sformatf("s%0d first lock cycle", idx), 32'(first_lock), 32'(s.exp_lock_cyc));
    checkOutput($sformatf("s%0d slip spacing", idx), 32'(gap_err), 32'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    cyc          = 0;
    drv          = '0;
    prev_drv     = '0;
    exp_all_prev = 1'b0;
    exp_lock_cyc = 0;
    rand_mode    = 1'b0;
    loopback     = 1'b1;
    glitch_cyc   = 0;
    glitch_mask  = '0;
    for (int lane = 0; lane < DW; lane++) begin
      base[lane] = 4'b0011;
      rot[lane] = 0;
      pulses[lane] = 0;
      last_pulse[lane] = 0;
    end
    i_rst_n       = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_pardata = '0;

    #3;
    checkOutput("reset bitslip", 32'(bus.o_bitslip), 32'd0);
    checkOutput("reset lane_locked", 32'(bus.o_lane_locked), 32'd0);
    checkOutput("reset lane_fail", 32'(bus.o_lane_fail), 32'd0);
    checkOutput("reset all_locked", 32'(bus.o_all_locked), 32'd0);
    checkOutput("reset pardata_vld", 32'(bus.o_pardata_vld), 32'd0);
    checkOutput("reset pardata", 32'(bus.o_pardata), 32'd0);
    repeat (2) @(negedge i_fclk);
    i_rst_n = 1'b1;
    @(negedge i_fclk);

    // base/slips nibbles are lane3..lane0
    scen[0] = mk(16'h3333, 1'b1, 0,  4'b0000, 16'h0000, 4'hF, 4'h0, 13);
    scen[1] = mk(16'h3C33, 1'b1, 0,  4'b0000, 16'h0200, 4'hF, 4'h0, 25);
    scen[2] = mk(16'h3330, 1'b1, 0,  4'b0000, 16'h0007, 4'hE, 4'h1, 0);
    scen[3] = mk(16'h9336, 1'b1, 0,  4'b0000, 16'h1003, 4'hF, 4'h0, 31);
    scen[4] = mk(16'h3333, 1'b0, 10, 4'b0010, 16'h0010, 4'hF, 4'h0, 24);
    scen[5] = mk(16'h69CF, 1'b1, 0,  4'b0000, 16'h3127, 4'hE, 4'h1, 0);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(scen[i], i);
    end

    // Reset asserted while lane 2 is emitting its first bitslip pulse.
    $display("[TB] reset during slip");
    for (int lane = 0; lane < DW; lane++) base[lane] = 4'b0011;
    base[2]      = 4'b1100;
    loopback     = 1'b1;
    glitch_mask  = '0;
    exp_lock_cyc = 0;
    startTraining();
    repeat (6) stepCycle();
    checkOutput("slip pulse before reset", 32'(bus.o_bitslip), 32'h4);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("async reset bitslip", 32'(bus.o_bitslip), 32'd0);
    checkOutput("async reset lane_locked", 32'(bus.o_lane_locked), 32'd0);
    checkOutput("async reset lane_fail", 32'(bus.o_lane_fail), 32'd0);
    checkOutput("async reset all_locked", 32'(bus.o_all_locked), 32'd0);
    checkOutput("async reset pardata_vld", 32'(bus.o_pardata_vld), 32'd0);
    checkOutput("async reset pardata", 32'(bus.o_pardata), 32'd0);
    @(negedge i_fclk);
    i_rst_n      = 1'b1;
    exp_all_prev = 1'b0;
    for (int lane = 0; lane < DW; lane++) pulses[lane] = 0;
    repeat (10) stepCycle();
    checkOutput("idle after reset slips", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);
    checkOutput("idle after reset locked", 32'(bus.o_lane_locked), 32'd0);

    // Lock, stream random data, then restart training while locked.
    $display("[TB] restart while locked");
    base[2]      = 4'b0011;
    exp_lock_cyc = 13;
    startTraining();
    repeat (20) stepCycle();
    checkOutput("locked before restart", 32'(bus.o_lane_locked), 32'hF);
    rand_mode = 1'b1;
    repeat (15) stepCycle();
    checkOutput("lock held on random data", 32'(bus.o_lane_locked), 32'hF);
    rand_mode = 1'b0;
    startTraining();
    stepCycle();
    checkOutput("restart clears lock", 32'(bus.o_lane_locked), 32'd0);
    repeat (14) stepCycle();
    checkOutput("relock after restart", 32'(bus.o_lane_locked), 32'hF);
    checkOutput("relock first cycle", 32'(first_lock), 32'd13);
    checkOutput("relock slips", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/selectio_bitslip_align.md
Name: selectio_bitslip_align

Overview:
- Word-alignment controller that sits directly downstream of select_io's deserializer (ISERDES) output, in the i_fclk domain.
- Consumes the lane-reordered parallel word stream and drives the per-lane i_bitslip of select_io until every lane shows the training pattern.
- Then forwards aligned parallel data with a valid flag to downstream logic.
- Replaces ad-hoc bitslip logic in test_selectio.

Parameters:
- DW, 4: number of serial data lanes.
- SP_Mult, 4: deserialization factor, i.e. bits per lane per i_fclk word.
- TRAIN_PAT, 4'b0011: expected per-lane training word (SP_Mult bits).
- SETTLE_CYC, 4: cycles waited after reset release or a bitslip before comparing (range 1..15).
- MATCH_CNT, 8: consecutive matches required to declare lock (range 1..255).
- MAX_SLIP, 7: bitslips allowed per lane before FAIL (default 2*SP_Mult-1).

Ports:
- i_fclk  in  1  deserializer parallel clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; starts or restarts training on all lanes.
- i_pardata  in  DW*SP_Mult  deserialized word. Bit [DW*k+lane] is sample k of that lane.
- o_bitslip  out  DW  one-cycle bitslip pulse per lane, to select_io i_bitslip.
- o_lane_locked  out  DW  per-lane lock status.
- o_lane_fail  out  DW  per-lane training failure.
- o_all_locked  out  1  AND of o_lane_locked.
- o_pardata  out  DW*SP_Mult  i_pardata registered once.
- o_pardata_vld  out  1  registered with o_pardata; high when o_all_locked was high on the same sample edge.

Behaviour:
- Reset (async assert, sync use on deassert): all outputs 0, every lane FSM in IDLE, all counters 0.
- Lane word: lw[lane] = {i_pardata[DW*(SP_Mult-1)+lane], ..., i_pardata[DW+lane], i_pardata[lane]}. Compare lw[lane] == TRAIN_PAT.
- Each lane has an independent FSM with a settle counter, a match counter (8b) and a slip counter.
- IDLE: wait for i_start.
- Any state, i_start=1: next state WAIT; clear settle, match and slip counters; clear locked and fail. i_start has priority over every other transition.
- WAIT: stays exactly SETTLE_CYC cycles, then goes to CHECK. Comparisons are ignored while in WAIT.
- CHECK, match: match_cnt++. When match_cnt reaches MATCH_CNT, go to LOCKED; o_lane_locked rises the following edge.
- CHECK, mismatch: match_cnt=0.
  - If slip_cnt == MAX_SLIP: go to FAIL.
  - Otherwise go to SLIP.
- SLIP: o_bitslip[lane]=1 for exactly one cycle, slip_cnt++, then WAIT. Consecutive pulses on a lane are therefore at least SETTLE_CYC+2 cycles apart.
- LOCKED: o_lane_locked=1. Data mismatches are ignored; only i_start or reset leave this state.
- FAIL: o_lane_fail=1. Only i_start or reset leave this state.
- Slip wrap-around: select_io rotates the word cyclically, so slips beyond SP_Mult-1 revisit earlier alignments. MAX_SLIP bounds the search.
- o_all_locked is combinational from the registered per-lane lock flags.
- o_pardata and o_pardata_vld are one-cycle-registered copies of i_pardata and o_all_locked.
- Reset mid-training: immediate return to reset values. Any in-flight bitslip pulse is dropped.

Test Plan:
1. Aligned lanes: all lanes carry 4'b0011 (i_pardata=16'h00FF), i_start at cycle 0 → WAIT cycles 1-4, CHECK 5-12, no o_bitslip, o_lane_locked=4'hF and o_all_locked from cycle 13, o_pardata_vld from cycle 14.
2. Lane 2 off by two positions (loopback model rotates lw[2] left by 1 per bitslip) → exactly two o_bitslip[2] pulses, 6 cycles apart. Other lanes lock at cycle 13. Lane 2 locks last, then o_all_locked=1.
3. Lane 0 constant 4'b0000 → exactly 7 o_bitslip[0] pulses, then o_lane_fail[0]=1, o_lane_locked[0]=0, o_all_locked stays 0.
4. Lane 1 matches 5 cycles, then one mismatch in CHECK → match count cleared, one o_bitslip[1] pulse, lock occurs 8 matches after the next WAIT.
5. i_rst_n low mid-SLIP → o_bitslip=0 and all status 0 asynchronously. Separately, i_start while all locked → o_all_locked drops next edge and training restarts with slip_cnt=0.
6. Data path: random i_pardata after lock → o_pardata equals i_pardata one cycle earlier bit-for-bit. o_pardata_vld=0 whenever o_all_locked was 0.
